// File: rtl/bpsk_ctrl_pkg.sv
// Shared state encoding and frame constants for the BPSK frame controller.
package bpsk_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    GUARD = 3'd4
  } state_e;

  localparam int PRE_LEN    = 8;
  localparam int DATA_LEN   = 8;
  localparam int FRAME_SYMS = PRE_LEN + DATA_LEN + 1;

  localparam logic [7:0] DEF_PRE_PATTERN = 8'hAA;

endpackage

// File: rtl/bpsk_sym_timer.sv
// Symbol period counter. sym_strobe marks the last cycle of each symbol so the
// controller can register the next symbol into its outputs on that edge.
module bpsk_sym_timer #(
  parameter int SYM_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sym_strobe
);

  localparam int            CW   = $clog2(SYM_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(SYM_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!run || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sym_strobe = run && wrap;

endmodule

// File: rtl/bpsk_frame_ctrl.sv
// Frame sequencer feeding a BPSK modulator: preamble, latched data byte and
// even parity, followed by a guard gap. Every output comes straight from a register.
module bpsk_frame_ctrl
  import bpsk_ctrl_pkg::*;
#(
  parameter int         SYM_CYCLES  = 16,
  parameter logic [7:0] PRE_PATTERN = DEF_PRE_PATTERN,
  parameter int         GUARD_SYMS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       busy,
  output logic       mod_en,
  output logic       mod_d,
  output logic       sym_strobe,
  output logic       done
);

  localparam int         GW        = (GUARD_SYMS > 1) ? $clog2(GUARD_SYMS) : 1;
  localparam logic [GW-1:0] LAST_GUARD = GW'(GUARD_SYMS - 1);
  localparam logic [2:0] LAST_PRE  = 3'(PRE_LEN - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_LEN - 1);

  state_e        state_q, state_d;
  logic [2:0]    bit_q, bit_d, nxt_bit;
  logic [GW-1:0] guard_q, guard_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          mod_en_q, mod_en_d;
  logic          mod_d_q, mod_d_d;
  logic          strobe_q, strobe_d;
  logic          done_q, done_d;
  logic          run;
  logic          sym_tick;

  assign run = (state_q != IDLE);

  bpsk_sym_timer #(
    .SYM_CYCLES(SYM_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .sym_strobe(sym_tick)
  );

  // Next-state values are what the outputs show in the following cycle, so a
  // symbol change and its strobe land together on the edge after sym_tick.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    guard_d  = guard_q;
    data_d   = data_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    mod_en_d = mod_en_q;
    mod_d_d  = mod_d_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    nxt_bit  = bit_q + 3'd1;

    case (state_q)
      IDLE: begin
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        mod_en_d = 1'b0;
        mod_d_d  = 1'b0;
        if (start && ready_q) begin
          state_d  = PRE;
          data_d   = data_in;
          bit_d    = 3'd0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          mod_en_d = 1'b1;
          mod_d_d  = PRE_PATTERN[7];
          strobe_d = 1'b1;
        end
      end
      PRE: begin
        if (sym_tick) begin
          strobe_d = 1'b1;
          if (bit_q == LAST_PRE) begin
            state_d = DATA;
            bit_d   = 3'd0;
            mod_d_d = data_q[7];
          end else begin
            bit_d   = nxt_bit;
            mod_d_d = PRE_PATTERN[LAST_PRE - nxt_bit];
          end
        end
      end
      DATA: begin
        if (sym_tick) begin
          strobe_d = 1'b1;
          if (bit_q == LAST_DATA) begin
            state_d = PAR;
            bit_d   = 3'd0;
            mod_d_d = ^data_q;
          end else begin
            bit_d   = nxt_bit;
            mod_d_d = data_q[LAST_DATA - nxt_bit];
          end
        end
      end
      PAR: begin
        if (sym_tick) begin
          state_d  = GUARD;
          guard_d  = '0;
          mod_en_d = 1'b0;
          mod_d_d  = 1'b0;
        end
      end
      GUARD: begin
        if (sym_tick) begin
          if (guard_q == LAST_GUARD) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            guard_d = guard_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bit_q    <= 3'd0;
      guard_q  <= '0;
      data_q   <= 8'h00;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      mod_en_q <= 1'b0;
      mod_d_q  <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      guard_q  <= guard_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      mod_en_q <= mod_en_d;
      mod_d_q  <= mod_d_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign mod_en     = mod_en_q;
  assign mod_d      = mod_d_q;
  assign sym_strobe = strobe_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bpsk_frame_ctrl.sv
// Scoreboard bench for bpsk_frame_ctrl: directed frames on a 4-cycle-symbol
// instance and a 2-cycle-symbol instance, both with a two-symbol guard.
module tb_bpsk_frame_ctrl;
  import bpsk_ctrl_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         accCyc;
  } frame_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int SYM         = (g == 0) ? 4 : 2;
    localparam int DONE_OFFSET = (FRAME_SYMS + 2) * SYM + 1;

    logic       rst;
    logic       start;
    logic [7:0] dataIn;
    logic       ready, busy, modEn, modD, symStrobe, doneP;
    logic       finished = 1'b0;
    logic       symQ[$];
    frame_t     frameQ[$];
    int         lastStrobe = 0;
    int         symIdx = 0;
    int         enCycles = 0;
    logic       curSym = 1'b0;

    bpsk_frame_ctrl #(
      .SYM_CYCLES (SYM),
      .PRE_PATTERN(8'hAA),
      .GUARD_SYMS (2)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data_in   (dataIn),
      .ready     (ready),
      .busy      (busy),
      .mod_en    (modEn),
      .mod_d     (modD),
      .sym_strobe(symStrobe),
      .done      (doneP)
    );

    // Monitor: each strobe consumes one expected symbol, each done consumes one frame.
    always @(negedge clk) begin
      frame_t f;
      if (rst === 1'b0) begin
        if (modEn === 1'b1) enCycles++;
        if (symStrobe === 1'b1) begin
          checkOutput("strobe has pending symbol", 32'(symQ.size() != 0), 1);
          if (symIdx == 0 && frameQ.size() != 0)
            checkOutput("first strobe offset", cyc - frameQ[0].accCyc + 1, 1);
          else if (symIdx != 0)
            checkOutput("strobe spacing", cyc - lastStrobe, SYM);
          if (symQ.size() != 0) begin
            curSym = symQ.pop_front();
            checkOutput("mod_d at strobe", modD, curSym);
          end
          checkOutput("mod_en at strobe", modEn, 1);
          lastStrobe = cyc;
          symIdx++;
        end else if (modEn === 1'b1) begin
          checkOutput("mod_d hold", modD, curSym);
        end else if (busy === 1'b1) begin
          checkOutput("guard mod_d", modD, 0);
        end
        if (doneP === 1'b1) begin
          checkOutput("done has pending frame", 32'(frameQ.size() != 0), 1);
          if (frameQ.size() != 0) begin
            f = frameQ.pop_front();
            checkOutput("done offset", cyc - f.accCyc + 1, DONE_OFFSET);
          end
          checkOutput("mod_en cycles", enCycles, FRAME_SYMS * SYM);
          checkOutput("ready at done", ready, 1);
          checkOutput("busy at done", busy, 0);
          checkOutput("symbols left at done", symQ.size(), 0);
          enCycles = 0;
          symIdx   = 0;
        end
      end
    end

    task automatic pushExpected(input logic [7:0] data, input logic [16:0] expSyms,
                                input int acc);
      frame_t f;
      for (int i = 16; i >= 0; i--) symQ.push_back(expSyms[i]);
      f.data   = data;
      f.accCyc = acc;
      frameQ.push_back(f);
    endtask

    task automatic resetDut(input int edges);
      rst = 1'b1;
      start = 1'b0;
      dataIn = 8'h00;
      repeat (edges) @(posedge clk);
      #1;
      checkOutput("reset ready", ready, 1);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset mod_en", modEn, 0);
      checkOutput("reset mod_d", modD, 0);
      checkOutput("reset sym_strobe", symStrobe, 0);
      checkOutput("reset done", doneP, 0);
      symQ.delete();
      frameQ.delete();
      enCycles = 0;
      symIdx = 0;
      curSym = 1'b0;
      rst = 1'b0;
    endtask

    // Returns one cycle after the accepting edge; data_in is scrambled afterwards
    // unless start is held for a back-to-back request.
    task automatic applyStimulus(input logic [7:0] data, input logic [16:0] expSyms,
                                 input logic hold, output int acc);
      start = 1'b1;
      dataIn = data;
      @(posedge clk);
      #1;
      acc = cyc;
      pushExpected(data, expSyms, acc);
      if (!hold) begin
        start = 1'b0;
        dataIn = ~data;
      end
    endtask

    task automatic waitIdle(input string name);
      for (int i = 0; i < 200 && frameQ.size() != 0; i++) begin
        @(negedge clk);
        #1;
      end
      checkOutput(name, frameQ.size(), 0);
    endtask

    if (g == 0) begin : g_main
      initial begin
        int acc;
        resetDut(2);

        applyStimulus(8'hA5, 17'b10101010_10100101_0, 1'b0, acc);
        waitIdle("frame A5 completes");

        applyStimulus(8'hA5, 17'b10101010_10100101_0, 1'b0, acc);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        dataIn = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle("frame A5 with ignored start completes");
        repeat (20) @(negedge clk);
        checkOutput("no frame after ignored start", busy, 0);

        applyStimulus(8'h01, 17'b10101010_00000001_1, 1'b0, acc);
        waitIdle("frame 01 completes");
        applyStimulus(8'h00, 17'b10101010_00000000_0, 1'b0, acc);
        waitIdle("frame 00 completes");

        applyStimulus(8'hA5, 17'b10101010_10100101_0, 1'b0, acc);
        repeat (29) @(posedge clk);
        #1;
        resetDut(1);
        repeat (10) @(negedge clk);
        checkOutput("idle after abort", busy, 0);
        applyStimulus(8'h3C, 17'b10101010_00111100_0, 1'b0, acc);
        waitIdle("frame 3C after abort completes");

        applyStimulus(8'h5A, 17'b10101010_01011010_0, 1'b1, acc);
        for (int i = 0; i < 200 && cyc != acc + DONE_OFFSET; i++) begin
          @(posedge clk);
          #1;
        end
        pushExpected(8'h5A, 17'b10101010_01011010_0, acc + DONE_OFFSET);
        start = 1'b0;
        waitIdle("back-to-back frames complete");
        repeat (20) @(negedge clk);
        checkOutput("idle after held start released", busy, 0);
        finished = 1'b1;
      end
    end else begin : g_short
      initial begin
        int acc;
        resetDut(2);
        applyStimulus(8'hA5, 17'b10101010_10100101_0, 1'b0, acc);
        waitIdle("two-cycle-symbol frame A5 completes");
        repeat (10) @(negedge clk);
        checkOutput("two-cycle-symbol idle after frame", busy, 0);
        finished = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 5000 && !(g_inst[0].finished && g_inst[1].finished); i++)
      @(posedge clk);
    checkOutput("stimulus finished in time",
                32'(g_inst[0].finished && g_inst[1].finished), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bpsk_frame_ctrl.md
BPSK_FRAME_CTRL -- requirements
Module: bpsk_frame_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst is sampled on the rising edge of clk.
REQ-002 The block SHALL have these parameters:
- SYM_CYCLES, default 16, clk cycles per BPSK symbol; legal values are 2 or more.
- PRE_PATTERN, default 8'hAA, 8-bit preamble, sent MSB first.
- GUARD_SYMS, default 2, number of idle symbol periods after each frame; legal values are 1 or more.
REQ-003 clk  in  1  system clock, shared with the modulator.
REQ-004 rst  in  1  synchronous reset, active high.
REQ-005 start  in  1  request to send one frame; qualified by ready.
REQ-006 data_in  in  8  payload byte, captured when start and ready are both high.
REQ-007 ready  out  1  high when the block can accept start.
REQ-008 busy  out  1  high while a frame is in progress, including the guard period.
REQ-009 mod_en  out  1  drives the modulator enable input.
REQ-010 mod_d  out  1  drives the modulator data input.
REQ-011 sym_strobe  out  1  one-cycle pulse in the first cycle of each transmitted symbol.
REQ-012 done  out  1  one-cycle pulse when the block returns to IDLE after a frame.

Function
REQ-013 The FSM SHALL have the states IDLE, PRE, DATA, PAR and GUARD. All outputs SHALL be registered.
REQ-014 In IDLE: ready=1, busy=0, mod_en=0, mod_d=0.
REQ-015 At a rising edge where start=1 and ready=1, the block SHALL latch data_in and go to PRE. In the next cycle: mod_en=1, mod_d=PRE_PATTERN[7], sym_strobe=1, ready=0, busy=1.
REQ-016 start SHALL be ignored whenever ready=0. data_in changes after acceptance SHALL NOT affect the frame in progress.
REQ-017 Each symbol SHALL hold mod_d constant for exactly SYM_CYCLES cycles. The symbol counter SHALL be ceil(log2(SYM_CYCLES)) bits wide and SHALL wrap from SYM_CYCLES-1 to 0.
REQ-018 Symbol order SHALL be:
- 8 preamble bits, MSB first;
- 8 latched data bits, MSB first;
- 1 even-parity bit (XOR of the latched data).
This is 17 symbols in total, with mod_en=1 for all of them.
REQ-019 GUARD SHALL last GUARD_SYMS*SYM_CYCLES cycles with mod_en=0, mod_d=0, sym_strobe=0 and busy=1.
REQ-020 At the end of GUARD the state SHALL become IDLE. In that same cycle done=1 and ready=1.
REQ-021 A start asserted in the done cycle SHALL be accepted, giving back-to-back frames with no extra idle cycle.
REQ-022 No symbol SHALL be truncated or extended at any state boundary.

Reset
REQ-023 While rst=1, the next clock edge SHALL force:
- state=IDLE;
- ready=1, busy=0, mod_en=0, mod_d=0, sym_strobe=0, done=0;
- all counters and the data register cleared.
REQ-024 Reset during a frame SHALL abort the frame immediately with no done pulse. rst SHALL take priority over start.

Structure
REQ-025 A package bpsk_ctrl_pkg SHALL hold:
- the state enum;
- the constants PRE_LEN=8, DATA_LEN=8 and FRAME_SYMS=17;
- the default PRE_PATTERN.
REQ-026 The symbol counter and strobe generation SHALL be in one sub-module, bpsk_sym_timer, with ports clk, rst, run and sym_strobe. The FSM SHALL advance bits on sym_strobe.

Verification (all scenarios use SYM_CYCLES=4, GUARD_SYMS=2)
REQ-027 data_in=0xA5, start pulse -> mod_d over 17 symbols of 4 cycles each = 10101010 10100101 0. mod_en=1 for 68 cycles, then 0 for 8 cycles. done=1 in the 77th cycle after acceptance.
REQ-028 data_in=0x01 -> parity symbol = 1. data_in=0x00 -> parity symbol = 0.
REQ-029 start with data_in=0xFF asserted in cycle 10 of a 0xA5 frame -> ignored: the 0xA5 frame completes unchanged and no second frame follows.
REQ-030 rst=1 in cycle 30 of a frame -> on the next edge mod_en=0, ready=1, busy=0, and no done pulse. A new start with data_in=0x3C then produces a correct full frame.
REQ-031 start held high continuously with data_in=0x5A -> second frame begins in the cycle after the done cycle, and sym_strobe spacing stays exactly 4 cycles.
REQ-032 Repeat REQ-027 with SYM_CYCLES=2 -> mod_en high for 34 cycles, and done in the 39th cycle after acceptance.
